imm_encode: RTL
===============

# imm_encode

Pipelined RISC-V immediate encoder: takes a signed/unsigned 32-bit immediate plus an immediate type and produces the 25-bit instruction field holding instruction bits [31:7], with every non-immediate position zero. It is the inverse of the decode-stage immediate extender and uses the same type encoding. It sits in the instruction-injection and self-test path, where generated immediates are packed into instruction words. Two register stages with valid/ready handshaking on both sides; unrepresentable immediates are flagged and counted.

## Interface
- No parameters; all widths fixed.
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at a clk edge
- imm_in  input  32  immediate value, two's complement, byte offset for B/J
- imm_type  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101–111 invalid
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- imm_field  output  25  packed field; field bit k = instruction bit k+7
- out_err  output  1  immediate not representable, or invalid type
- err_cnt  output  8  saturating count of errored results handed off

## Operation
- Packing, using field bit positions:
  - I: [24:13] = imm[11:0].
  - S: [24:18] = imm[11:5], [4:0] = imm[4:0].
  - B: [24] = imm[12], [23:18] = imm[10:5], [4:1] = imm[4:1], [0] = imm[11].
  - J: [24] = imm[20], [23:14] = imm[10:1], [13] = imm[11], [12:5] = imm[19:12].
  - U: [24:5] = imm[31:12].
  - All unlisted field bits are 0.
- Error rules; out_err = 1 when:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] = 1.
  - J: imm[31:20] not all equal, or imm[0] = 1.
  - U: imm[11:0] != 0.
  - Type 101–111: always; imm_field = 0 for these types.
- On a range or alignment error, imm_field still carries the truncated packing.
- Stage 1 registers imm_in, imm_type and the error result. Stage 2 registers the packed field and out_err.
- Stage-advance rules:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load.
  - This is a combinational ready chain with no bubbles at full throughput.
- A stage's valid clears when its data moves on and nothing replaces it.
- err_cnt increments by 1 on each handoff with out_err = 1 (out_valid && out_ready). It holds at 255 and clears only on reset.

## Timing
- Reset (rst_n low, asynchronous):
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - imm_field = 0, out_err = 0, err_cnt = 0.
  - in_ready = 1 combinationally while in reset or once the pipeline is empty.
- Latency: a request accepted at edge N gives out_valid = 1 after edge N+1, with output registered. Two register stages, minimum 2 edges from request to handoff at edge N+2.
- Throughput: with out_ready held at 1, one result per cycle.
- Backpressure:
  - With out_ready = 0, at most two requests are held.
  - in_ready drops to 0 in the cycle both stages are valid.
  - in_ready rises combinationally in the same cycle out_ready rises.
- imm_field and out_err are stable while out_valid && !out_ready.
- Simultaneous handoff and accept in one cycle: both occur, and occupancy is unchanged.
- Reset asserted mid-operation: all in-flight results are discarded and no handoff is reported. err_cnt is not incremented for a result that was on the output when reset asserted.

## Test plan
- I, imm_in = 0xFFFFFFFF, out_ready = 1 -> after 2 edges imm_field = 0x1FFE000, out_err = 0.
- S, imm_in = 0x000007FF -> imm_field = 0x0FC001F, out_err = 0.
- S, imm_in = 0x00000800 -> out_err = 1, err_cnt = 1 after handoff.
- B, imm_in = 0x00000800 -> imm_field = 0x0000001, out_err = 0.
- B, imm_in = 0x00000003 -> out_err = 1.
- J, imm_in = 0xFFF00000 -> imm_field = 0x1000000, out_err = 0.
- J, imm_in = 0x00100000 -> out_err = 1.
- U, imm_in = 0x12345000 -> imm_field = 0x02468A0, out_err = 0.
- U, imm_in = 0x12345001 -> out_err = 1.
- Type 110 -> imm_field = 0, out_err = 1.
- Backpressure: out_ready = 0, three back-to-back requests (I with 1, 2, 3).
  - Two accepted, then in_ready = 0.
  - out_ready = 1 -> fields 0x0002000, 0x0004000, 0x0006000 in order on consecutive cycles, no loss or duplication.
- Saturation and reset:
  - 260 errored handoffs -> err_cnt = 255.
  - rst_n pulsed low with both stages full -> out_valid = 0 and err_cnt = 0 immediately.
  - Next request completes normally 2 edges after acceptance.

Source files
------------

// File: rtl/imm_encode.sv
// RISC-V immediate encoder: packs a 32-bit immediate into instruction bits [31:7] and flags unrepresentable immediates.
// Latency: two register stages; a request accepted at edge N is handed off at edge N+2 at the earliest.
// Backpressure: combinational ready chain holds at most two results and stalls in_ready only when both stages are full.
module imm_encode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm_in,
    input  logic [2:0]  imm_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] imm_field,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    localparam logic [2:0] TYPE_I = 3'd0;
    localparam logic [2:0] TYPE_S = 3'd1;
    localparam logic [2:0] TYPE_B = 3'd2;
    localparam logic [2:0] TYPE_J = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_imm_q,   s1_imm_d;
    logic [2:0]  s1_type_q,  s1_type_d;
    logic        s1_err_q,   s1_err_d;
    logic        s2_valid_q, s2_valid_d;
    logic [24:0] s2_field_q, s2_field_d;
    logic        s2_err_q,   s2_err_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;

    logic        s1_load;
    logic        s2_load;
    logic        in_err;
    logic [24:0] pack;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // Range check: the bits above the encodable width must be a pure sign extension.
    always_comb begin
        in_err = 1'b0;
        case (imm_type)
            TYPE_I, TYPE_S: in_err = !((&imm_in[31:11]) || !(|imm_in[31:11]));
            TYPE_B:         in_err = !((&imm_in[31:12]) || !(|imm_in[31:12])) || imm_in[0];
            TYPE_J:         in_err = !((&imm_in[31:20]) || !(|imm_in[31:20])) || imm_in[0];
            TYPE_U:         in_err = |imm_in[11:0];
            default:        in_err = 1'b1;
        endcase
    end

    always_comb begin
        pack = '0;
        case (s1_type_q)
            TYPE_I: pack[24:13] = s1_imm_q[11:0];
            TYPE_S: begin
                pack[24:18] = s1_imm_q[11:5];
                pack[4:0]   = s1_imm_q[4:0];
            end
            TYPE_B: begin
                pack[24]    = s1_imm_q[12];
                pack[23:18] = s1_imm_q[10:5];
                pack[4:1]   = s1_imm_q[4:1];
                pack[0]     = s1_imm_q[11];
            end
            TYPE_J: begin
                pack[24]    = s1_imm_q[20];
                pack[23:14] = s1_imm_q[10:1];
                pack[13]    = s1_imm_q[11];
                pack[12:5]  = s1_imm_q[19:12];
            end
            TYPE_U:  pack[24:5] = s1_imm_q[31:12];
            default: pack = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_type_d  = s1_type_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_field_d = s2_field_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_imm_d  = imm_in;
                s1_type_d = imm_type;
                s1_err_d  = in_err;
            end
        end

        // Output data only changes when stage 2 is free to take new data, keeping it stable under stall.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_field_d = pack;
                s2_err_d   = s1_err_q;
            end
        end

        if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_type_q  <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_field_q <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_type_q  <= s1_type_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_field_q <= s2_field_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign imm_field = s2_field_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
